// File: rtl/global_stats_dumper.sv
// global_stats_dumper: snapshots the global statistics counters on request and
// streams them as a framed packet (header, counter words low-word-first,
// XOR checksum trailer) over a valid/ready output port.
module global_stats_dumper #(
    parameter int NUM_COUNTERS  = 4,
    parameter int COUNTER_WIDTH = 64,
    parameter int OUT_WIDTH     = 32
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_COUNTERS*COUNTER_WIDTH-1:0] counters_in,
    input  logic                                  dump_req,
    output logic                                  busy,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [OUT_WIDTH-1:0]                  out_data,
    output logic                                  out_last,
    output logic [7:0]                            dropped_reqs,
    output logic [1:0]                            dbg_state
);

    // Output handshake: a word transfers on a rising edge where
    // out_valid && out_ready. While out_valid is high and out_ready is low,
    // out_data and out_last hold. out_valid is a function of registered state
    // only (never of out_ready) and only drops after the trailer transfers or
    // on reset.

    localparam int WPC         = COUNTER_WIDTH / OUT_WIDTH;
    localparam int TOTAL_WORDS = NUM_COUNTERS * WPC;
    localparam int SNAP_W      = NUM_COUNTERS * COUNTER_WIDTH;
    localparam int IDX_W       = (TOTAL_WORDS > 1) ? $clog2(TOTAL_WORDS) : 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_HEADER  = 2'd1;
    localparam logic [1:0] ST_DATA    = 2'd2;
    localparam logic [1:0] ST_TRAILER = 2'd3;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL_WORDS - 1);

    // Magic in the top 16 bits, counter count in the low byte; with a 16-bit
    // port the magic takes precedence where the two fields overlap.
    function automatic logic [OUT_WIDTH-1:0] build_header();
        logic [OUT_WIDTH-1:0] h;
        h                    = '0;
        h[7:0]               = 8'(NUM_COUNTERS);
        h[OUT_WIDTH-1 -: 16] = 16'h5A7A;
        return h;
    endfunction

    localparam logic [OUT_WIDTH-1:0] HEADER_WORD = build_header();

    logic [1:0]           state;
    logic [IDX_W-1:0]     idx;
    logic [SNAP_W-1:0]    snapshot;
    logic [OUT_WIDTH-1:0] checksum;
    logic [OUT_WIDTH-1:0] xor_in;
    logic [OUT_WIDTH-1:0] data_word;
    logic                 xfer;

    assign xfer      = out_valid && out_ready;
    assign busy      = (state != ST_IDLE);
    assign out_valid = (state != ST_IDLE);
    assign out_last  = (state == ST_TRAILER);
    assign dbg_state = state;
    assign data_word = snapshot[int'(idx)*OUT_WIDTH +: OUT_WIDTH];

    // Trailer value precomputed from the live counters so it can be latched
    // together with the snapshot on the accepting edge.
    always_comb begin
        xor_in = HEADER_WORD;
        for (int w = 0; w < TOTAL_WORDS; w++) begin
            xor_in = xor_in ^ counters_in[w*OUT_WIDTH +: OUT_WIDTH];
        end
    end

    // Output word mux; idle drives zero so the bus is quiet between frames.
    always_comb begin
        out_data = '0;
        case (state)
            ST_HEADER:  out_data = HEADER_WORD;
            ST_DATA:    out_data = data_word;
            ST_TRAILER: out_data = checksum;
            default:    out_data = '0;
        endcase
    end

    // Frame FSM: snapshot on request, then walk header, data words, trailer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            idx      <= '0;
            snapshot <= '0;
            checksum <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (dump_req) begin
                        snapshot <= counters_in;
                        checksum <= xor_in;
                        idx      <= '0;
                        state    <= ST_HEADER;
                    end
                end
                ST_HEADER: begin
                    if (xfer) begin
                        idx   <= '0;
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (xfer) begin
                        if (idx == LAST_IDX) begin
                            state <= ST_TRAILER;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                ST_TRAILER: begin
                    if (xfer) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Saturating count of requests that arrive while a frame is in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            dropped_reqs <= '0;
        end else if (dump_req && (state != ST_IDLE) && (dropped_reqs != 8'hFF)) begin
            dropped_reqs <= dropped_reqs + 8'd1;
        end
    end

endmodule

// File: tb/tb_global_stats_dumper.sv
// Directed bench for global_stats_dumper: a model pushes each expected frame
// into a queue when a dump is requested; a negedge monitor pops and compares
// every transferred word and checks that stalled words hold.
module tb_global_stats_dumper;

    localparam int NC = 4;
    localparam int CW = 64;
    localparam int OW = 32;
    localparam int NW = NC * CW / OW;

    logic             clk = 1'b0;
    logic             reset;
    logic [NC*CW-1:0] counters_in;
    logic             dump_req;
    logic             busy;
    logic             out_valid;
    logic             out_ready;
    logic [OW-1:0]    out_data;
    logic             out_last;
    logic [7:0]       dropped_reqs;
    logic [1:0]       dbg_state;

    logic [OW:0] exp_q[$];   // {last, data}
    int          n_vec  = 0;
    int          n_fail = 0;
    int          xfer_cnt = 0;
    logic        prev_stall = 1'b0;
    logic [OW:0] prev_word;

    global_stats_dumper #(.NUM_COUNTERS(NC), .COUNTER_WIDTH(CW), .OUT_WIDTH(OW)) dut (
        .clk          (clk),
        .reset        (reset),
        .counters_in  (counters_in),
        .dump_req     (dump_req),
        .busy         (busy),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .dropped_reqs (dropped_reqs),
        .dbg_state    (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected frame for a given snapshot.
    task automatic push_frame(input logic [NC*CW-1:0] c);
        logic [OW-1:0] cs;
        logic [OW-1:0] w;
        cs = 32'h5A7A_0004;
        exp_q.push_back({1'b0, cs});
        for (int i = 0; i < NW; i++) begin
            w  = c[i*OW +: OW];
            cs = cs ^ w;
            exp_q.push_back({1'b0, w});
        end
        exp_q.push_back({1'b1, cs});
    endtask

    task automatic dump(input logic [NC*CW-1:0] c);
        counters_in = c;
        dump_req    = 1'b1;
        push_frame(c);
        xfer_cnt    = 0;
        tick();
        dump_req    = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        check(tag, 64'(busy), 64'd0);
    endtask

    task automatic wait_last(input string tag, input int budget);
        int n = 0;
        while (!out_last && n < budget) begin
            tick();
            n++;
        end
        check(tag, 64'(out_last), 64'd1);
    endtask

    // Scoreboard monitor: sampled mid-cycle, a handshake seen here transfers at
    // the next rising edge.
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_hold", 64'({out_valid, out_last, out_data}), 64'({1'b1, prev_word}));
            end
            if (out_valid && out_ready) begin
                xfer_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 64'({out_last, out_data}), 64'hDEAD_DEAD_DEAD_DEAD);
                end else begin
                    check("word", 64'({out_last, out_data}), 64'(exp_q.pop_front()));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_word  = {out_last, out_data};
        end
    end

    logic [NC*CW-1:0] c1;
    logic [NC*CW-1:0] c2;
    int               stall_left;
    int               n;

    initial begin
        c1 = {64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'h1_0000_0002, 64'd1};
        reset       = 1'b1;
        dump_req    = 1'b0;
        out_ready   = 1'b0;
        counters_in = '0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_last", 64'(out_last), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_dropped", 64'(dropped_reqs), 64'd0);

        // 1: full-rate frame, exact 10-cycle length
        out_ready = 1'b1;
        dump(c1);
        check("t1_hdr_valid", 64'(out_valid), 64'd1);
        check("t1_hdr_data", 64'(out_data), 64'h5A7A_0004);
        check("t1_busy", 64'(busy), 64'd1);
        repeat (9) tick();
        check("t1_last_at_10", 64'({busy, out_last}), 64'b11);
        tick();
        check("t1_busy_fall", 64'({busy, out_valid}), 64'd0);
        check("t1_q_empty", 64'(exp_q.size()), 64'd0);

        // 2: ready toggling with a 5-cycle stall on word 3
        tick();
        out_ready = 1'b0;
        dump(c1);
        stall_left = 5;
        n = 0;
        while (busy && n < 200) begin
            if (xfer_cnt == 3 && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = ~out_ready;
            end
            tick();
            n++;
        end
        check("t2_idle", 64'(busy), 64'd0);
        check("t2_q_empty", 64'(exp_q.size()), 64'd0);

        // 3: counters change every cycle during the frame
        tick();
        out_ready = 1'b1;
        c2 = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'hA5A5_5A5A_0F0F_F0F0, 64'h1111_2222_3333_4444};
        dump(c2);
        n = 0;
        while (busy && n < 50) begin
            counters_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            tick();
            n++;
        end
        check("t3_idle", 64'(busy), 64'd0);
        check("t3_q_empty", 64'(exp_q.size()), 64'd0);

        // 4: requests during a frame, including the trailer-transfer cycle
        tick();
        dump(c1);
        tick();
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        tick();
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        wait_last("t4_reach_trailer", 20);
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        check("t4_dropped", 64'(dropped_reqs), 64'd3);
        tick();
        tick();
        check("t4_no_second_frame", 64'({busy, out_valid}), 64'd0);
        check("t4_q_empty", 64'(exp_q.size()), 64'd0);

        // 4b: hold request for 300 busy cycles -> saturation
        out_ready = 1'b0;
        dump(c1);
        dump_req = 1'b1;
        repeat (300) tick();
        dump_req = 1'b0;
        check("t4_busy_held", 64'(busy), 64'd1);
        check("t4_saturate", 64'(dropped_reqs), 64'd255);
        out_ready = 1'b1;
        wait_idle("t4_drain", 50);
        check("t4b_q_empty", 64'(exp_q.size()), 64'd0);

        // 5: reset at data word 4 while stalled
        tick();
        out_ready = 1'b1;
        dump(c2);
        n = 0;
        while (xfer_cnt < 5 && n < 20) begin
            tick();
            n++;
        end
        check("t5_reach_word4", 64'(xfer_cnt), 64'd5);
        out_ready = 1'b0;
        reset     = 1'b1;
        exp_q.delete();
        tick();
        reset = 1'b0;
        check("t5_valid", 64'(out_valid), 64'd0);
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_dropped", 64'(dropped_reqs), 64'd0);
        out_ready = 1'b1;
        dump(c1);
        wait_idle("t5_refill", 20);
        check("t5_q_empty", 64'(exp_q.size()), 64'd0);

        // 6: request on the edge right after a trailer transfer
        tick();
        dump(c2);
        wait_last("t6_reach_trailer", 20);
        tick();
        check("t6_idle_gap", 64'(busy), 64'd0);
        dump(c1);
        check("t6_new_hdr", 64'({out_valid, out_data}), 64'({1'b1, 32'h5A7A_0004}));
        check("t6_dropped", 64'(dropped_reqs), 64'd0);
        wait_idle("t6_drain", 20);
        check("t6_q_empty", 64'(exp_q.size()), 64'd0);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
